// File: rtl/regfile_wb_demux_pkg.sv
// Shared constants for the write-back register file: register IDs, widths
// and the default sizing used by the top level and the destination decoder.
package regfile_wb_demux_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_NREGS  = 15;
  localparam int WR_COUNT_W     = 16;

  // Stack pointer register ID and the "no register" ID.
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/regfile_wb_demux_dest_decoder.sv
// Destination decoder: turns a 4-bit register ID plus an enable into a
// one-hot write strobe. ID 0xF (RNONE), any ID beyond the register count,
// or a low enable gives an all-zero strobe.
module dest_decoder
  import regfile_wb_demux_pkg::*;
#(
  parameter int N_OUT = DEFAULT_NREGS
) (
  input  logic [3:0]       i_id,
  input  logic             i_en,
  output logic [N_OUT-1:0] o_strobe
);

  // One-hot decode; RNONE never matches because it is excluded explicitly.
  always_comb begin
    o_strobe = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (i_en && (i_id != RNONE) && (i_id == 4'(i))) begin
        o_strobe[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_demux.sv
// Write-back register file with two write ports (E and M) and two read ports
// (A and B). Each write port is demultiplexed by its own dest_decoder; when
// both ports target the same register the M port wins and the event counts
// as a single write. Reads are purely combinational from the stored values,
// so a register being written reads its old value until the next cycle.
module regfile_wb_demux
  import regfile_wb_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NREGS  = DEFAULT_NREGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [3:0]            dstE,
  input  logic [DATA_W-1:0]     valE,
  input  logic [3:0]            dstM,
  input  logic [DATA_W-1:0]     valM,
  input  logic [3:0]            srcA,
  input  logic [3:0]            srcB,
  output logic [DATA_W-1:0]     valA,
  output logic [DATA_W-1:0]     valB,
  output logic [WR_COUNT_W-1:0] wr_count
);

  logic [DATA_W-1:0]     r_regs [NREGS];
  logic [WR_COUNT_W-1:0] r_wr_count;

  logic [NREGS-1:0]      w_strb_e_raw;
  logic [NREGS-1:0]      w_strb_e;
  logic [NREGS-1:0]      w_strb_m;
  logic [1:0]            w_n_writes;
  logic [DATA_W-1:0]     w_val_a;
  logic [DATA_W-1:0]     w_val_b;

  dest_decoder #(.N_OUT(NREGS)) u_dec_e (
    .i_id     (dstE),
    .i_en     (wr_en),
    .o_strobe (w_strb_e_raw)
  );

  dest_decoder #(.N_OUT(NREGS)) u_dec_m (
    .i_id     (dstM),
    .i_en     (wr_en),
    .o_strobe (w_strb_m)
  );

  // M has priority: drop the E strobe for any register M is also writing,
  // which also makes a same-destination collision count as one write.
  assign w_strb_e   = w_strb_e_raw & ~w_strb_m;
  assign w_n_writes = {1'b0, |w_strb_e} + {1'b0, |w_strb_m};

  // Register array and commit counter; reset discards any concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_strb_m[i]) begin
          r_regs[i] <= valM;
        end else if (w_strb_e[i]) begin
          r_regs[i] <= valE;
        end
      end
      r_wr_count <= r_wr_count + {{(WR_COUNT_W-2){1'b0}}, w_n_writes};
    end
  end

  // Read ports: select by ID, zero for RNONE or any unimplemented ID.
  always_comb begin
    w_val_a = '0;
    w_val_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (srcA == 4'(i)) w_val_a = r_regs[i];
      if (srcB == 4'(i)) w_val_b = r_regs[i];
    end
  end

  assign valA     = w_val_a;
  assign valB     = w_val_b;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_wb_demux.sv
// Bench for regfile_wb_demux: directed scenarios followed by random traffic,
// all checked against an array-based reference model of the register file.
module tb_regfile_wb_demux;
  import regfile_wb_demux_pkg::*;

  localparam int DW = 64;
  localparam int NR = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [3:0]    dstE, dstM, srcA, srcB;
  logic [DW-1:0] valE, valM;
  logic [DW-1:0] valA, valB;
  logic [15:0]   wr_count;

  // Reference model state.
  logic [DW-1:0] m_regs [NR];
  logic [15:0]   m_count;

  int n_pass = 0;
  int n_total = 0;

  regfile_wb_demux #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .dstE     (dstE),
    .valE     (valE),
    .dstM     (dstM),
    .valM     (valM),
    .srcA     (srcA),
    .srcB     (srcB),
    .valA     (valA),
    .valB     (valB),
    .wr_count (wr_count)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] m_read(input logic [3:0] id);
    if (id == RNONE || int'(id) >= NR) return '0;
    return m_regs[id];
  endfunction

  // Model of one rising edge: reset clears everything; otherwise write E
  // then M (so M wins a collision) and count distinct registers written.
  task automatic m_edge(input logic rst, input logic we, input logic [3:0] de,
                        input logic [DW-1:0] ve, input logic [3:0] dm,
                        input logic [DW-1:0] vm);
    int n;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_count = '0;
    end else if (we) begin
      n = 0;
      if (de != RNONE) begin m_regs[de] = ve; n++; end
      if (dm != RNONE) begin m_regs[dm] = vm; if (dm != de) n++; end
      m_count = m_count + 16'(n);
    end
  endtask

  // Drive one cycle. Inputs change #1 after a rising edge; reads are
  // checked before and after the next edge, wr_count after it.
  task automatic cyc(input string tag, input logic rst, input logic we,
                     input logic [3:0] de, input logic [DW-1:0] ve,
                     input logic [3:0] dm, input logic [DW-1:0] vm,
                     input logic [3:0] sa, input logic [3:0] sb, input bit do_chk);
    reset = rst; wr_en = we; dstE = de; valE = ve; dstM = dm; valM = vm;
    srcA = sa; srcB = sb;
    #1;
    if (do_chk) begin
      chk({tag, ":valA_pre"}, valA, m_read(sa));
      chk({tag, ":valB_pre"}, valB, m_read(sb));
    end
    @(posedge clk);
    m_edge(rst, we, de, ve, dm, vm);
    #1;
    if (do_chk) begin
      chk({tag, ":valA_post"}, valA, m_read(sa));
      chk({tag, ":valB_post"}, valB, m_read(sb));
      chk({tag, ":wr_count"}, DW'(wr_count), DW'(m_count));
    end
  endtask

  // Sweep every read ID (including RNONE) through both ports, no writes.
  task automatic chk_all(input string tag);
    reset = 1'b0; wr_en = 1'b0; dstE = RNONE; dstM = RNONE;
    for (int i = 0; i < 16; i++) begin
      srcA = 4'(i); srcB = 4'(15 - i);
      #1;
      chk({tag, ":sweepA"}, valA, m_read(4'(i)));
      chk({tag, ":sweepB"}, valB, m_read(4'(15 - i)));
    end
    chk({tag, ":count"}, DW'(wr_count), DW'(m_count));
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 'x;
    m_count = 'x;
    reset = 1'b1; wr_en = 1'b0; dstE = RNONE; dstM = RNONE;
    valE = '0; valM = '0; srcA = RNONE; srcB = RNONE;

    // Reset state.
    @(posedge clk); m_edge(1'b1, 1'b0, RNONE, '0, RNONE, '0); #1;
    cyc("reset", 1'b1, 1'b0, RNONE, '0, RNONE, '0, 4'h0, 4'hF, 1'b1);
    chk_all("reset");

    // Reset clear, including a write presented together with reset.
    cyc("wr3", 1'b0, 1'b1, 4'h3, 64'h1234, RNONE, '0, 4'h3, 4'h3, 1'b1);
    cyc("rst_wr", 1'b1, 1'b1, 4'h3, 64'h5555, 4'h6, 64'h66, 4'h3, 4'h6, 1'b1);
    chk_all("after_rst");

    // Dual write.
    cyc("dual", 1'b0, 1'b1, 4'h2, 64'hAA, 4'h5, 64'hBB, 4'h2, 4'h5, 1'b1);
    chk({"dual:cnt"}, DW'(wr_count), 64'd2);

    // Same destination collision on the stack pointer.
    cyc("coll", 1'b0, 1'b1, RRSP, 64'h10, RRSP, 64'h20, RRSP, 4'h2, 1'b1);
    chk("coll:reg4", valA, 64'h20);
    chk("coll:cnt", DW'(wr_count), 64'd3);

    // No-write cases.
    cyc("none_ff", 1'b0, 1'b1, RNONE, 64'h77, RNONE, 64'h88, 4'hF, 4'h5, 1'b1);
    cyc("wr_dis", 1'b0, 1'b0, 4'h1, 64'h99, 4'h2, 64'h98, 4'h1, 4'h2, 1'b1);
    chk_all("nowrite");

    // No bypass: old value visible in the write cycle, new value after.
    cyc("b7a", 1'b0, 1'b1, 4'h7, 64'h5, RNONE, '0, 4'h0, 4'h7, 1'b1);
    reset = 1'b0; wr_en = 1'b1; dstE = 4'h7; valE = 64'h9; dstM = RNONE; srcB = 4'h7;
    #1; chk("bypass:same", valB, 64'h5);
    @(posedge clk); m_edge(1'b0, 1'b1, 4'h7, 64'h9, RNONE, '0); #1;
    chk("bypass:next", valB, 64'h9);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      cyc("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)), {$urandom, $urandom},
          4'($urandom_range(0, 15)), {$urandom, $urandom},
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    end
    chk_all("rand_end");

    // Counter wrap: 65535 single writes then one dual write.
    cyc("wrap_rst", 1'b1, 1'b0, RNONE, '0, RNONE, '0, RNONE, RNONE, 1'b1);
    for (int k = 0; k < 65535; k++) begin
      cyc("fill", 1'b0, 1'b1, 4'(k % NR), 64'(k), RNONE, '0, RNONE, RNONE, 1'b0);
    end
    chk("wrap:ffff", DW'(wr_count), 64'hFFFF);
    cyc("wrap_dual", 1'b0, 1'b1, 4'h0, 64'h1, 4'h1, 64'h2, 4'h0, 4'h1, 1'b1);
    chk("wrap:0001", DW'(wr_count), 64'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_demux.md
REGFILE_WB_DEMUX -- requirements
Module: regfile_wb_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register data width.
REQ-002 SHALL have parameter NREGS, default 15, number of architectural registers (IDs 0x0-0xE).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1, write-back enable for the current instruction.
REQ-006 SHALL have port dstE, input, 4, destination ID for the E write port; 0xF means no write.
REQ-007 SHALL have port valE, input, DATA_W, data for the E write port.
REQ-008 SHALL have port dstM, input, 4, destination ID for the M write port; 0xF means no write.
REQ-009 SHALL have port valM, input, DATA_W, data for the M write port.
REQ-010 SHALL have ports srcA and srcB, input, 4 each, read-port register IDs; 0xF means none.
REQ-011 SHALL have ports valA and valB, output, DATA_W each, read-port data.
REQ-012 SHALL have port wr_count, output, 16, count of register writes committed since reset.

Function
REQ-013 SHALL one-hot decode each destination ID into NREGS write strobes; ID 0xF asserts no strobe.
REQ-014 SHALL write valE to register dstE and valM to register dstM on the rising edge when wr_en=1.
REQ-015 SHALL update no register and leave wr_count unchanged when wr_en=0.
REQ-016 SHALL give the M port priority when dstE==dstM!=0xF: the register takes valM, and the event counts as one write.
REQ-017 SHALL write both registers in the same cycle when dstE!=dstM and both are not 0xF.
REQ-018 SHALL drive valA and valB combinationally from the current register contents, with no write-to-read bypass; a read of a register being written returns the old value until the next cycle.
REQ-019 SHALL drive 0 on valA or valB when the corresponding src is 0xF.
REQ-020 SHALL add the number of distinct registers written (0, 1 or 2) to wr_count each enabled cycle.
REQ-021 SHALL let wr_count wrap from 0xFFFF to the next modulo value without saturating.

Reset
REQ-022 SHALL, with reset=1 on a rising edge, clear all NREGS registers and wr_count to 0.
REQ-023 SHALL give reset priority over any simultaneous write: a reset mid-instruction discards the write.
REQ-024 SHALL therefore read 0 on valA and valB from the first cycle after reset.

Structure
REQ-025 SHALL take its constants from a shared package: register IDs RRSP=4'h4 and RNONE=4'hF, plus the default DATA_W.
REQ-026 SHALL implement the write-side demultiplexing in one sub-module, dest_decoder: a 4-bit ID plus enable in, a 15-bit one-hot strobe out, all-zero for 0xF or when disabled.
REQ-027 SHALL instantiate dest_decoder twice, once per write port, and combine the strobes with M-port priority.

Verification
REQ-028 SHALL cover reset clear: write 0x1234 to reg 3, then assert reset one cycle -> valA(srcA=3)=0, wr_count=0.
REQ-029 SHALL cover a dual write: wr_en=1, dstE=2/valE=0xAA, dstM=5/valM=0xBB -> next cycle reg2=0xAA, reg5=0xBB, wr_count+=2.
REQ-030 SHALL cover a same-destination collision: dstE=dstM=4, valE=0x10, valM=0x20 -> reg4=0x20, wr_count+=1.
REQ-031 SHALL cover no-write cases: dstE=0xF with dstM=0xF, or wr_en=0 with dstE=1 -> all registers and wr_count unchanged; srcA=0xF -> valA=0.
REQ-032 SHALL cover no bypass: reg7=0x5, write 0x9 to reg 7 while srcB=7 -> valB=0x5 in the same cycle, 0x9 in the next.
REQ-033 SHALL cover counter wrap: preload wr_count to 0xFFFF through 65535 single writes, then one dual write -> wr_count=0x0001.
